// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage constants, bus layouts and load-op encodings.
// The MEM stage and register file use the same definitions.
package wb_stage_pkg;

  localparam int MEM_TO_WB_WD = 108;
  localparam int WB_TO_RF_WD  = 38;
  localparam int WB_TO_ID_WD  = 38;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LBU  = 3'b010,
    LD_LH   = 3'b011,
    LD_LHU  = 3'b100,
    LD_LW   = 3'b101
  } ld_op_e;

  // MSB->LSB field order matches the MEM-stage bus packing.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic [31:0] mem_rdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_to_rf_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load-data extraction: byte/halfword select with sign/zero extension,
// plus alignment check for halfword and word loads.
module load_extend
  import wb_stage_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_rdata_i,
  output logic        is_load_o,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Reserved encodings 110/111 fall through as "no load".
  always_comb begin
    is_load_o  = 1'b1;
    data_o     = '0;
    misalign_o = 1'b0;
    case (ld_op_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'd0, byte_sel};
      LD_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o     = {16'd0, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LD_LW: begin
        data_o     = mem_rdata_i;
        misalign_o = (addr_lo_i != 2'd0);
      end
      default: is_load_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds the MEM result, extends load data, drives the
// regfile write port, an identical ID bypass copy, trace and retire count.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
  output logic [WB_TO_ID_WD-1:0]  wb_to_id_bus,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata,
  output logic                    misalign_err,
  output logic [31:0]             retired_cnt
);

  mem_to_wb_t  wb_q, wb_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    wb_d = mem_to_wb_bus;
    if (flush)         wb_d = '0;
    else if (stall[5]) wb_d = wb_q;
    else if (stall[4]) wb_d = '0;
    retired_d = retired_q;
    if (wb_q.valid && !stall[5]) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  logic        ext_is_load, ext_misalign;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .ld_op_i     (wb_q.ld_op),
    .addr_lo_i   (wb_q.addr_lo),
    .mem_rdata_i (wb_q.mem_rdata),
    .is_load_o   (ext_is_load),
    .data_o      (ext_data),
    .misalign_o  (ext_misalign)
  );

  logic        mis, we;
  logic [31:0] wdata;
  wb_to_rf_t   rf_w;

  // Stale fields of a bubble must never raise an error or a write.
  assign mis   = wb_q.valid & ext_misalign;
  assign wdata = ext_is_load ? ext_data : wb_q.rf_wdata;
  assign we    = wb_q.valid & wb_q.rf_we & (wb_q.rf_waddr != 5'd0) & ~mis;

  assign rf_w.we    = we;
  assign rf_w.waddr = wb_q.rf_waddr;
  assign rf_w.wdata = wdata;

  assign wb_to_rf_bus      = rf_w;
  assign wb_to_id_bus      = rf_w;
  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{we}};
  assign debug_wb_rf_wnum  = wb_q.rf_waddr;
  assign debug_wb_rf_wdata = wdata;
  assign misalign_err      = mis;
  assign retired_cnt       = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected outputs queued at drive time,
// popped and compared one cycle later.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [5:0]              stall;
  logic                    flush;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus;
  logic [WB_TO_ID_WD-1:0]  wb_to_id_bus;
  logic [31:0]             debug_wb_pc;
  logic [3:0]              debug_wb_rf_wen;
  logic [4:0]              debug_wb_rf_wnum;
  logic [31:0]             debug_wb_rf_wdata;
  logic                    misalign_err;
  logic [31:0]             retired_cnt;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_to_rf_bus      (wb_to_rf_bus),
    .wb_to_id_bus      (wb_to_id_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .misalign_err      (misalign_err),
    .retired_cnt       (retired_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] cnt_m;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic mem_to_wb_t ent(input logic [31:0] pc, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] ld,
      input logic [1:0] alo, input logic [31:0] rd);
    mem_to_wb_t m;
    m = '{valid: 1'b1, pc: pc, rf_we: we, rf_waddr: wa, rf_wdata: wd,
          ld_op: ld, addr_lo: alo, mem_rdata: rd};
    return m;
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic mis);
    exp_t e;
    e = '{valid: 1'b1, we: we, waddr: wa, wdata: wd, pc: pc, mis: mis, cnt: 32'd0};
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".rf"},    {25'd0, wb_to_rf_bus}, {25'd0, e.we, e.waddr, e.wdata});
    chk({tag, ".id"},    {25'd0, wb_to_id_bus}, {25'd0, e.we, e.waddr, e.wdata});
    chk({tag, ".pc"},    {32'd0, debug_wb_pc}, {32'd0, e.pc});
    chk({tag, ".wen"},   {60'd0, debug_wb_rf_wen}, {60'd0, {4{e.we}}});
    chk({tag, ".wnum"},  {59'd0, debug_wb_rf_wnum}, {59'd0, e.waddr});
    chk({tag, ".wdata"}, {32'd0, debug_wb_rf_wdata}, {32'd0, e.wdata});
    chk({tag, ".mis"},   {63'd0, misalign_err}, {63'd0, e.mis});
    chk({tag, ".cnt"},   {32'd0, retired_cnt}, {32'd0, e.cnt});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag, input mem_to_wb_t in, input logic [5:0] st,
      input logic fl, input exp_t e_new);
    exp_t nxt;
    if (fl)         nxt = '0;
    else if (st[5]) nxt = cur;
    else if (st[4]) nxt = '0;
    else            nxt = e_new;
    if (cur.valid && !st[5]) cnt_m = cnt_m + 32'd1;
    nxt.cnt = cnt_m;
    sb.push_back(nxt);
    cur = nxt;
    mem_to_wb_bus = in;
    stall = st;
    flush = fl;
    @(posedge clk); #1;
    compare_out(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    cur = '0;
    cnt_m = 32'd0;
    sb.push_back('0);
    @(posedge clk); #1;
    compare_out(tag);
    @(negedge clk);
    rst = 1'b1;
    stall = 6'd0;
    flush = 1'b0;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  mem_to_wb_t e_hold;

  initial begin
    rst = 1'b0; stall = 6'd0; flush = 1'b0; mem_to_wb_bus = '0;
    cur = '0; cnt_m = 32'd0;
    @(negedge clk);
    mem_to_wb_bus = ent(32'h1, 1'b1, 5'd3, 32'h5, 3'd0, 2'd0, 32'h0);
    do_reset("reset");

    step("alu", ent(32'h1000, 1, 5, 32'h1234_5678, 3'b000, 0, 32'h0), 0, 0,
         ex(32'h1000, 1, 5, 32'h1234_5678, 0));
    step("lb3",  ent(32'h1004, 1, 6, 32'hDEAD, 3'b001, 3, RD), 0, 0,
         ex(32'h1004, 1, 6, 32'hFFFF_FF80, 0));
    step("lbu2", ent(32'h1008, 1, 7, 32'hDEAD, 3'b010, 2, RD), 0, 0,
         ex(32'h1008, 1, 7, 32'h0000_00FF, 0));
    step("lh2",  ent(32'h100C, 1, 8, 32'hDEAD, 3'b011, 2, RD), 0, 0,
         ex(32'h100C, 1, 8, 32'hFFFF_80FF, 0));
    step("lhu0", ent(32'h1010, 1, 10, 32'hDEAD, 3'b100, 0, RD), 0, 0,
         ex(32'h1010, 1, 10, 32'h0000_7F01, 0));
    step("lw0",  ent(32'h1014, 1, 11, 32'hDEAD, 3'b101, 0, RD), 0, 0,
         ex(32'h1014, 1, 11, RD, 0));
    step("op110", ent(32'h1018, 1, 12, 32'hCAFE_0001, 3'b110, 1, RD), 0, 0,
         ex(32'h1018, 1, 12, 32'hCAFE_0001, 0));
    step("lwmis", ent(32'h101C, 1, 9, 32'hDEAD, 3'b101, 1, RD), 0, 0,
         ex(32'h101C, 0, 9, RD, 1));
    step("lhmis", ent(32'h1020, 1, 13, 32'hDEAD, 3'b011, 3, RD), 0, 0,
         ex(32'h1020, 0, 13, 32'hFFFF_80FF, 1));
    step("wa0",  ent(32'h1024, 1, 0, 32'h7777_0000, 3'b000, 0, 32'h0), 0, 0,
         ex(32'h1024, 0, 0, 32'h7777_0000, 0));

    // Hold for three cycles, then bubble, then flush beating stall[5].
    e_hold = ent(32'h2000, 1, 7, 32'hAABB_CCDD, 3'b000, 0, 32'h0);
    step("hold.cap", e_hold, 0, 0, ex(32'h2000, 1, 7, 32'hAABB_CCDD, 0));
    for (int i = 0; i < 3; i++)
      step("hold", ent(32'h3000 + i, 1, 14, 32'h1111 * i, 3'b000, 0, 0), 6'b110000, 0, '0);
    step("bubble", ent(32'h4000, 1, 15, 32'h4444, 3'b000, 0, 0), 6'b010000, 0, '0);
    step("fl.cap", e_hold, 0, 0, ex(32'h2000, 1, 7, 32'hAABB_CCDD, 0));
    step("flush", ent(32'h5000, 1, 16, 32'h5555, 3'b000, 0, 0), 6'b100000, 1, '0);

    // Counter wrap: preload the counter, then retire one entry.
    step("wrap.cap", e_hold, 0, 0, ex(32'h2000, 1, 7, 32'hAABB_CCDD, 0));
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    cnt_m = 32'hFFFF_FFFF;
    chk("wrap.preload", {32'd0, retired_cnt}, {32'd0, 32'hFFFF_FFFF});
    step("wrap", ent(32'h6000, 1, 17, 32'h6666, 3'b000, 0, 0), 0, 0,
         ex(32'h6000, 1, 17, 32'h6666, 0));

    // Reset while an entry is held discards it.
    step("rst.hold", ent(32'h7000, 1, 18, 32'h7777, 3'b000, 0, 0), 6'b110000, 0, '0);
    stall = 6'b110000;
    do_reset("rst.mid");
    step("post.rst", ent(32'h8000, 1, 19, 32'h8888, 3'b010, 0, RD), 0, 0,
         ex(32'h8000, 1, 19, 32'h0000_0001, 0));
    step("post.rst2", '0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback pipeline stage and the write-side counterpart of the register file's forwarding read ports. Captures the MEM-stage result bus, performs load-data byte/halfword extraction and sign/zero extension, and drives the register-file write port. In the same cycle it drives an identical copy onto the ID-stage bypass bus, so a same-cycle reader never sees stale data. It also produces the debug trace outputs and a retired-instruction counter.

## Interface
- `MEM_TO_WB_WD`, 108 – width of `mem_to_wb_bus`; fields MSB→LSB: valid(1), pc(32), rf_we(1), rf_waddr(5), rf_wdata(32), ld_op(3), addr_lo(2), mem_rdata(32).
- `WB_TO_RF_WD`, 38 – fields MSB→LSB: we(1), waddr(5), wdata(32); same layout used for `WB_TO_ID_WD`.
- `clk` in 1 – single clock, all state on rising edge.
- `rst` in 1 – synchronous, active-low reset.
- `stall` in 6 – pipeline stall vector; this stage uses bits 4 and 5.
- `flush` in 1 – kill the entry being captured this edge.
- `mem_to_wb_bus` in `MEM_TO_WB_WD` – MEM-stage result.
- `wb_to_rf_bus` out `WB_TO_RF_WD` – register-file write port.
- `wb_to_id_bus` out `WB_TO_ID_WD` – bypass copy for ID-stage forwarding, lowest priority after EX and MEM.
- `debug_wb_pc` out 32; `debug_wb_rf_wen` out 4; `debug_wb_rf_wnum` out 5; `debug_wb_rf_wdata` out 32 – trace.
- `misalign_err` out 1 – pulse: current entry is a misaligned halfword or word load.
- `retired_cnt` out 32 – count of valid entries retired.

## Operation
- Holding register `wb_r` is `MEM_TO_WB_WD` bits wide. Update priority at each edge:
  - `rst`=0 → clear `wb_r`, clear `retired_cnt`.
  - `flush`=1 → clear `wb_r`.
  - `stall[5]`=1 → hold `wb_r`.
  - `stall[4]`=1 and `stall[5]`=0 → clear `wb_r` (insert bubble).
  - Otherwise → `wb_r <= mem_to_wb_bus`.
- Result select from the registered fields. `ld_op` encodings:
  - 000 → `rf_wdata` (no load).
  - 001 lb → sign-extended byte `addr_lo` of `mem_rdata`.
  - 010 lbu → zero-extended byte `addr_lo`.
  - 011 lh → sign-extended halfword; upper half if `addr_lo[1]`=1.
  - 100 lhu → zero-extended halfword, same half selection.
  - 101 lw → `mem_rdata`.
  - 110/111 → treated as 000.
- Misalignment:
  - Halfword load with `addr_lo[0]`=1, or lw with `addr_lo`≠0 → `misalign_err`=1.
  - While `misalign_err`=1, the write is suppressed (we=0).
- Effective write enable: we = valid & rf_we & (rf_waddr≠0) & ~misalign_err.
- `wb_to_id_bus` is bit-identical to `wb_to_rf_bus` every cycle.
- Trace outputs:
  - `debug_wb_pc` = registered pc.
  - `debug_wb_rf_wen` = {4{we}}.
  - `debug_wb_rf_wnum` = waddr.
  - `debug_wb_rf_wdata` = selected data.
- Retired counter: `retired_cnt` increments by 1 at each edge where the current entry is valid and `stall[5]`=0, misaligned entries included. It wraps 0xFFFF_FFFF→0.

## Timing
- Latency: 1 cycle from `mem_to_wb_bus` to all outputs. Outputs are combinational from `wb_r` only; no combinational path from any input.
- The register-file write commits at the edge after `wb_to_rf_bus` is asserted. During that cycle the reader's bypass supplies the value via `wb_to_id_bus`.
- Held entry under `stall[5]`:
  - The write port stays asserted with the same waddr/wdata; rewriting the same value is harmless.
  - `retired_cnt` does not advance while held.
- Reset values:
  - All outputs 0 at the first edge with `rst`=0, including `misalign_err`=0 and `retired_cnt`=0.
  - Reset mid-stall discards the held entry.
- `flush` and `stall[5]` asserted together → flush wins.
- Bubble: valid=0 forces we=0 and `misalign_err`=0, regardless of the stale fields.

## Structure
- `MEM_TO_WB_WD`, `WB_TO_RF_WD`, `WB_TO_ID_WD` and the `ld_op` encodings live in the shared `defines.vh`. The MEM stage and regfile use the same constants.
- One natural sub-module: `load_extend` – combinational (ld_op, addr_lo, mem_rdata) → (data, misalign). Everything else stays in `wb_stage`.

## Test plan
- Plain ALU write: valid, we=1, waddr=5, wdata=0x1234_5678 → next cycle `wb_to_rf_bus`=`wb_to_id_bus`={1,5,0x1234_5678}; `debug_wb_rf_wen`=0xF; `retired_cnt`=1 after the following edge.
- Loads of mem_rdata=0x80FF_7F01 (each → required data):
  - lb addr_lo=3 → 0xFFFF_FF80.
  - lbu addr_lo=2 → 0x0000_00FF.
  - lh addr_lo=2 → 0xFFFF_80FF.
  - lhu addr_lo=0 → 0x0000_7F01.
- Misaligned lw addr_lo=1, waddr=9 → `misalign_err`=1, we=0, `retired_cnt` still increments.
- waddr=0 with we=1 → we output 0 and `debug_wb_rf_wen`=0.
- Stall and flush sequencing:
  - `stall`=6'b110000 for 3 cycles → entry held, outputs constant, `retired_cnt` frozen.
  - Then `stall`=6'b010000 → bubble (all write outputs 0).
  - `flush`=1 together with `stall[5]`=1 → cleared.
- Counter wrap and reset: preload `retired_cnt` to 0xFFFF_FFFF via a long stream, retire one → 0. Assert `rst`=0 mid-stream → all outputs 0 the next cycle.
